weight_preload_sequencer: RTL and testbench
===========================================

# weight_preload_sequencer

Streams a flat sequence of signed weights into the systolic mesh's preload port, then launches computation. It sits directly upstream of the mesh top. It accepts weights over a valid/ready stream and generates row-major `{row, col}` preload addresses with matching `cfg_valid`/`cfg_data` beats. After the last weight is written it issues a single-cycle `start` pulse to the mesh controller.

## Interface
- `DW`, 8, weight width in bits (signed)
- `ROWS`, 8, mesh rows
- `COLS`, 32, mesh columns (need not be a power of two)
- `ROW_W`, 3, row index width
- `COL_W`, 5, column index width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `load_req`  in  1  begin a load; sampled only in IDLE
- `w_valid`  in  1  upstream weight beat valid
- `w_ready`  out  1  sequencer accepts beat; high only in LOAD
- `w_data`  in  DW  signed weight
- `cfg_valid`  out  1  preload write strobe to mesh
- `cfg_addr`  out  ROW_W+COL_W  `{row, col}` preload address
- `cfg_data`  out  DW  preload weight
- `start`  out  1  one-cycle compute launch pulse
- `busy`  out  1  high in any state other than IDLE
- `checksum`  out  16  running weight sum (see Configuration)

## Operation
- States: IDLE, LOAD, DRAIN, FIRE.
- IDLE: `load_req`=1 → LOAD next cycle. Row and col counters cleared to 0. Checksum cleared.
- LOAD: `w_ready`=1 (combinational from state). Each accept (`w_valid & w_ready`) captures `w_data` and the current `{row, col}` into output registers and advances the counters.
- Counter advance: col increments; at col==COLS-1, col←0 and row increments. The address is a concatenation, not `row*COLS+col`.
- Accepting the beat at row==ROWS-1, col==COLS-1 → DRAIN.
- DRAIN → FIRE → IDLE, unconditionally, one cycle each.
- `load_req` outside IDLE is ignored; it is neither queued nor restarting.
- Beats with `w_valid`=0 in LOAD stall the counters. No address is skipped or repeated.
- `w_data` in non-LOAD states is ignored.
- Reset mid-load: all state returns to IDLE and all outputs deassert. Weights already written to the mesh are not rolled back. The next load restarts at address 0.

## Timing
- Reset values: `w_ready`=0, `cfg_valid`=0, `cfg_addr`=0, `cfg_data`=0, `start`=0, `busy`=0, `checksum`=0.
- `load_req` high in IDLE at cycle c → `busy` and `w_ready` high at c+1.
- Accept at cycle t → `cfg_valid`=1 with that beat's addr/data at t+1. `cfg_valid` is 0 in any cycle following a non-accept.
- Last accept at t → last `cfg_valid` at t+1 (DRAIN) → `start`=1 at t+2 (FIRE) only → `busy`=0 at t+3.
- `start` never coincides with `cfg_valid`.
- Minimum load: ROWS·COLS+3 cycles from `load_req` to IDLE.
- `cfg_addr`/`cfg_data` hold their last values when `cfg_valid`=0.

## Configuration
- `WLOAD_CHECKSUM_EN` defined:
  - `checksum` accumulates each accepted `w_data`, sign-extended to 16 bits, with modulo-2^16 wraparound.
  - It is cleared when `load_req` is accepted.
  - It is final by the cycle `start` is high and holds until the next accepted `load_req`.
- Undefined: `checksum` is tied to 0 and no accumulator is synthesized.

## Test plan
- Full load, defaults: `load_req` pulse, then 256 back-to-back beats with `w_data`=i[7:0] → `cfg_addr`=i, `cfg_data`=i[7:0] at accept+1, in order. `start` is high exactly 2 cycles after the 256th accept. `busy` drops the cycle after.
- Bubbles: `w_valid` random at 50% duty over a full load → 256 `cfg_valid` beats, addresses 0..255 contiguous, no duplicates. `start` occurs once.
- Ignored request: `load_req` pulsed at beat 40 and again in DRAIN → no counter reset and no second `start`.
- Reset mid-load: `rst` at beat 100 → next cycle, all outputs are at reset values. A new load emits first `cfg_addr`=0.
- Checksum (macro on): 256 beats of `w_data`=8'hFF → `checksum`=16'hFF00 when `start` is high. With the macro off, `checksum`=0 throughout.
- Non-power-of-two: COLS=20, COL_W=5 → after `{row 0, col 19}` the next address is `{row 1, col 0}`. `start` follows the 8·20=160th accept by 2 cycles.

Source files
------------

// File: rtl/weight_preload_sequencer_if.sv
// Weight stream in, mesh preload/launch out.
// One bundle shared by the sequencer and its upstream/downstream peers.
interface weight_preload_sequencer_if #(
  parameter int DW    = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 5
);
  logic                   load_req;
  logic                   w_valid;
  logic                   w_ready;
  logic [DW-1:0]          w_data;
  logic                   cfg_valid;
  logic [ROW_W+COL_W-1:0] cfg_addr;
  logic [DW-1:0]          cfg_data;
  logic                   start;
  logic                   busy;
  logic [15:0]            checksum;

  modport master (
    output load_req,
    output w_valid,
    output w_data,
    input  w_ready,
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  start,
    input  busy,
    input  checksum
  );

  modport slave (
    input  load_req,
    input  w_valid,
    input  w_data,
    output w_ready,
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output start,
    output busy,
    output checksum
  );
endinterface

// File: rtl/weight_preload_sequencer.sv
// Streams weights into the mesh preload port row-major, then fires start.
// Optional running checksum: define WLOAD_CHECKSUM_EN.
module weight_preload_sequencer #(
  parameter int DW    = 8,
  parameter int ROWS  = 8,
  parameter int COLS  = 32,
  parameter int ROW_W = 3,
  parameter int COL_W = 5
) (
  input logic                        clk,
  input logic                        rst,
  weight_preload_sequencer_if.slave  bus
);

  localparam int AW = ROW_W + COL_W;

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_FIRE
  } state_e;

  state_e state_q, state_d;

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  logic          cfg_valid_q, cfg_valid_d;
  logic [AW-1:0] cfg_addr_q, cfg_addr_d;
  logic [DW-1:0] cfg_data_q, cfg_data_d;

  logic in_load;
  logic accept;
  logic col_end;
  logic last_beat;

  assign in_load   = (state_q == S_LOAD);
  assign accept    = in_load & bus.w_valid;
  assign col_end   = (col_q == COL_LAST);
  assign last_beat = col_end & (row_q == ROW_LAST);

  // Next-state, address counters and preload output capture
  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    cfg_valid_d = accept;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    unique case (state_q)
      S_IDLE: begin
        row_d = '0;
        col_d = '0;
        if (bus.load_req) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (accept) begin
          cfg_addr_d = {row_q, col_q};
          cfg_data_d = bus.w_data;
          if (col_end) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_beat) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_FIRE;
      S_FIRE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and registered preload port
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      row_q       <= '0;
      col_q       <= '0;
      cfg_valid_q <= 1'b0;
      cfg_addr_q  <= '0;
      cfg_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
    end
  end

  assign bus.w_ready   = in_load;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.start     = (state_q == S_FIRE);
  assign bus.cfg_valid = cfg_valid_q;
  assign bus.cfg_addr  = cfg_addr_q;
  assign bus.cfg_data  = cfg_data_q;

`ifdef WLOAD_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  // Sum restarts on an accepted request and holds once the load is done
  always_comb begin
    sum_d = sum_q;
    if ((state_q == S_IDLE) && bus.load_req) begin
      sum_d = '0;
    end else if (accept) begin
      sum_d = sum_q + 16'($signed(bus.w_data));
    end
  end

  // Checksum register
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign bus.checksum = sum_q;
`else
  assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// Directed bench for weight_preload_sequencer.
// Covers the default 8x32 mesh and a 8x20 non-power-of-two mesh.
module tb_weight_preload_sequencer;

`ifdef WLOAD_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  weight_preload_sequencer_if #(.DW(8), .ROW_W(3), .COL_W(5)) b ();
  weight_preload_sequencer_if #(.DW(8), .ROW_W(3), .COL_W(5)) b20 ();

  weight_preload_sequencer #(
    .DW(8), .ROWS(8), .COLS(32), .ROW_W(3), .COL_W(5)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  weight_preload_sequencer #(
    .DW(8), .ROWS(8), .COLS(20), .ROW_W(3), .COL_W(5)
  ) u_dut20 (
    .clk (clk),
    .rst (rst),
    .bus (b20)
  );

  task automatic idle_inputs();
    b.load_req   = 1'b0;
    b.w_valid    = 1'b0;
    b.w_data     = 8'h00;
    b20.load_req = 1'b0;
    b20.w_valid  = 1'b0;
    b20.w_data   = 8'h00;
  endtask

  task automatic reset_dut();
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({b.w_ready, b.cfg_valid, b.start, b.busy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl got %b exp 0000",
               {b.w_ready, b.cfg_valid, b.start, b.busy});
    end
    n_checks++;
    if ({b.cfg_addr, b.cfg_data} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_bus got %h exp 0000", {b.cfg_addr, b.cfg_data});
    end
    n_checks++;
    if (b.checksum !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_checksum got %h exp 0000", b.checksum);
    end
    n_checks++;
    if (b20.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy20 got %b exp 0", b20.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b.busy, b.w_ready} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_no_req got %b exp 00", {b.busy, b.w_ready});
    end
  endtask

  task automatic test_full_load();
    logic [15:0] sum;
    logic [7:0]  d;
    sum = 16'h0000;
    reset_dut();
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    n_checks++;
    if ({b.busy, b.w_ready} !== 2'b11) begin
      n_fail++;
      $display("FAIL full_enter got %b exp 11", {b.busy, b.w_ready});
    end
    for (int i = 0; i < 256; i++) begin
      d = i[7:0];
      b.w_valid = 1'b1;
      b.w_data  = d;
      @(negedge clk);
      sum = sum + {{8{d[7]}}, d};
      n_checks++;
      if ({b.cfg_valid, b.cfg_addr, b.cfg_data, b.start} !==
          {1'b1, d, d, 1'b0}) begin
        n_fail++;
        $display("FAIL full_beat i=%0d got v=%b a=%h d=%h s=%b exp a=%h d=%h",
                 i, b.cfg_valid, b.cfg_addr, b.cfg_data, b.start, d, d);
      end
    end
    n_checks++;
    if (b.w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain_ready got %b exp 0", b.w_ready);
    end
    b.w_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b.start, b.cfg_valid, b.busy, b.cfg_addr} !==
        {1'b1, 1'b0, 1'b1, 8'hFF}) begin
      n_fail++;
      $display("FAIL full_fire got s=%b v=%b busy=%b a=%h exp 1 0 1 ff",
               b.start, b.cfg_valid, b.busy, b.cfg_addr);
    end
    n_checks++;
    if (b.checksum !== (CK ? sum : 16'h0000)) begin
      n_fail++;
      $display("FAIL full_checksum got %h exp %h",
               b.checksum, CK ? sum : 16'h0000);
    end
    @(negedge clk);
    n_checks++;
    if ({b.start, b.busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL full_done got %b exp 00", {b.start, b.busy});
    end
    n_checks++;
    if (b.checksum !== (CK ? sum : 16'h0000)) begin
      n_fail++;
      $display("FAIL full_checksum_hold got %h exp %h",
               b.checksum, CK ? sum : 16'h0000);
    end
  endtask

  task automatic test_bubbles();
    int          acc;
    int          cyc;
    int          starts;
    logic        v;
    logic [7:0]  d;
    logic [15:0] sum;
    acc    = 0;
    cyc    = 0;
    starts = 0;
    sum    = 16'h0000;
    reset_dut();
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    while (acc < 256 && cyc < 3000) begin
      v = 1'($urandom_range(0, 1));
      d = 8'($urandom_range(0, 255));
      b.w_valid = v;
      b.w_data  = d;
      @(negedge clk);
      cyc++;
      if (b.start === 1'b1) starts++;
      n_checks++;
      if (v) begin
        if ({b.cfg_valid, b.cfg_addr, b.cfg_data} !==
            {1'b1, acc[7:0], d}) begin
          n_fail++;
          $display("FAIL bubble_beat n=%0d got v=%b a=%h d=%h exp a=%h d=%h",
                   acc, b.cfg_valid, b.cfg_addr, b.cfg_data, acc[7:0], d);
        end
        sum = sum + {{8{d[7]}}, d};
        acc++;
      end else if (b.cfg_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL bubble_idle n=%0d got v=%b exp 0", acc, b.cfg_valid);
      end
    end
    b.w_valid = 1'b0;
    n_checks++;
    if (acc != 256) begin
      n_fail++;
      $display("FAIL bubble_timeout got %0d beats exp 256", acc);
    end
    @(negedge clk);
    if (b.start === 1'b1) starts++;
    n_checks++;
    if ({b.start, b.cfg_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL bubble_fire got %b exp 10", {b.start, b.cfg_valid});
    end
    n_checks++;
    if (b.checksum !== (CK ? sum : 16'h0000)) begin
      n_fail++;
      $display("FAIL bubble_checksum got %h exp %h",
               b.checksum, CK ? sum : 16'h0000);
    end
    repeat (3) begin
      @(negedge clk);
      if (b.start === 1'b1) starts++;
    end
    n_checks++;
    if (starts != 1 || b.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_start_once got starts=%0d busy=%b exp 1 0",
               starts, b.busy);
    end
  endtask

  task automatic test_ignored_req();
    logic [7:0] d;
    reset_dut();
    b.load_req = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      d = i[7:0];
      b.load_req = (i == 40);
      b.w_valid  = 1'b1;
      b.w_data   = ~d;
      @(negedge clk);
      n_checks++;
      if ({b.cfg_valid, b.cfg_addr, b.cfg_data} !== {1'b1, d, ~d}) begin
        n_fail++;
        $display("FAIL ign_beat i=%0d got v=%b a=%h d=%h exp a=%h d=%h",
                 i, b.cfg_valid, b.cfg_addr, b.cfg_data, d, ~d);
      end
    end
    b.w_valid  = 1'b0;
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    n_checks++;
    if (b.start !== 1'b1) begin
      n_fail++;
      $display("FAIL ign_fire got %b exp 1", b.start);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({b.start, b.busy, b.w_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL ign_after k=%0d got %b exp 000",
                 k, {b.start, b.busy, b.w_ready});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    reset_dut();
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    for (int i = 0; i < 100; i++) begin
      d = i[7:0];
      b.w_valid = 1'b1;
      b.w_data  = d + 8'h80;
      @(negedge clk);
      n_checks++;
      if ({b.cfg_valid, b.cfg_addr} !== {1'b1, d}) begin
        n_fail++;
        $display("FAIL mid_beat i=%0d got v=%b a=%h exp a=%h",
                 i, b.cfg_valid, b.cfg_addr, d);
      end
    end
    b.w_data = 8'h33;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({b.w_ready, b.cfg_valid, b.start, b.busy, b.cfg_addr,
         b.cfg_data, b.checksum} !== 36'h0) begin
      n_fail++;
      $display("FAIL mid_reset got r=%b v=%b s=%b b=%b a=%h d=%h c=%h exp 0",
               b.w_ready, b.cfg_valid, b.start, b.busy,
               b.cfg_addr, b.cfg_data, b.checksum);
    end
    rst = 1'b0;
    b.w_valid = 1'b0;
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    b.w_valid = 1'b1;
    b.w_data  = 8'h5A;
    @(negedge clk);
    b.w_valid = 1'b0;
    n_checks++;
    if ({b.cfg_valid, b.cfg_addr, b.cfg_data} !== {1'b1, 8'h00, 8'h5A}) begin
      n_fail++;
      $display("FAIL mid_restart got v=%b a=%h d=%h exp 1 00 5a",
               b.cfg_valid, b.cfg_addr, b.cfg_data);
    end
    n_checks++;
    if (b.checksum !== (CK ? 16'h005A : 16'h0000)) begin
      n_fail++;
      $display("FAIL mid_checksum got %h exp %h",
               b.checksum, CK ? 16'h005A : 16'h0000);
    end
    @(negedge clk);
    n_checks++;
    if ({b.cfg_valid, b.cfg_addr, b.cfg_data} !== {1'b0, 8'h00, 8'h5A}) begin
      n_fail++;
      $display("FAIL mid_hold got v=%b a=%h d=%h exp 0 00 5a",
               b.cfg_valid, b.cfg_addr, b.cfg_data);
    end
  endtask

  task automatic test_checksum();
    reset_dut();
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    b.w_valid  = 1'b1;
    b.w_data   = 8'hFF;
    repeat (256) @(negedge clk);
    b.w_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b.start, b.checksum} !== {1'b1, (CK ? 16'hFF00 : 16'h0000)}) begin
      n_fail++;
      $display("FAIL cks_fire got s=%b c=%h exp 1 %h",
               b.start, b.checksum, CK ? 16'hFF00 : 16'h0000);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if ({b.busy, b.checksum} !== {1'b0, (CK ? 16'hFF00 : 16'h0000)}) begin
      n_fail++;
      $display("FAIL cks_hold got b=%b c=%h exp 0 %h",
               b.busy, b.checksum, CK ? 16'hFF00 : 16'h0000);
    end
    b.load_req = 1'b1;
    @(negedge clk);
    b.load_req = 1'b0;
    n_checks++;
    if ({b.busy, b.checksum} !== {1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL cks_clear got b=%b c=%h exp 1 0000",
               b.busy, b.checksum);
    end
  endtask

  task automatic test_npot();
    logic [2:0]  r;
    logic [4:0]  c;
    logic [7:0]  d;
    logic [15:0] sum;
    sum = 16'h0000;
    reset_dut();
    b20.load_req = 1'b1;
    @(negedge clk);
    b20.load_req = 1'b0;
    for (int i = 0; i < 160; i++) begin
      r = 3'(i / 20);
      c = 5'(i % 20);
      d = i[7:0];
      b20.w_valid = 1'b1;
      b20.w_data  = d;
      @(negedge clk);
      sum = sum + {{8{d[7]}}, d};
      n_checks++;
      if ({b20.cfg_valid, b20.cfg_addr, b20.cfg_data, b20.start} !==
          {1'b1, r, c, d, 1'b0}) begin
        n_fail++;
        $display("FAIL npot_beat i=%0d got v=%b a=%h d=%h exp a=%h d=%h",
                 i, b20.cfg_valid, b20.cfg_addr, b20.cfg_data, {r, c}, d);
      end
      if (i == 19) begin
        n_checks++;
        if (b20.cfg_addr !== 8'h13) begin
          n_fail++;
          $display("FAIL npot_row0_end got %h exp 13", b20.cfg_addr);
        end
      end
      if (i == 20) begin
        n_checks++;
        if (b20.cfg_addr !== 8'h20) begin
          n_fail++;
          $display("FAIL npot_row1_start got %h exp 20", b20.cfg_addr);
        end
      end
    end
    b20.w_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({b20.start, b20.cfg_valid, b20.cfg_addr} !== {2'b10, 8'hF3}) begin
      n_fail++;
      $display("FAIL npot_fire got s=%b v=%b a=%h exp 1 0 f3",
               b20.start, b20.cfg_valid, b20.cfg_addr);
    end
    n_checks++;
    if (b20.checksum !== (CK ? sum : 16'h0000)) begin
      n_fail++;
      $display("FAIL npot_checksum got %h exp %h",
               b20.checksum, CK ? sum : 16'h0000);
    end
    @(negedge clk);
    n_checks++;
    if ({b20.start, b20.busy, b.busy} !== 3'b000) begin
      n_fail++;
      $display("FAIL npot_done got %b exp 000",
               {b20.start, b20.busy, b.busy});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_load();
    test_bubbles();
    test_ignored_req();
    test_reset_mid();
    test_checksum();
    test_npot();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
